// File: rtl/e310_spi_arbiter.sv
// e310_spi_arbiter
// Two-master arbiter for the shared AD9361 SPI bus. Masters raise a
// level-sensitive req. The arbiter grants round-robin, passes the owner's
// SPI drive onto the shared bus, and routes MISO back to the owner. After
// each transaction the bus is held idle for GUARD_CYCLES cycles. A grant
// that is never used is revoked after GRANT_TIMEOUT cycles.
//
// Ports:
//   bus_clk, bus_rst            clock, synchronous active-high reset
//   req[1:0] / gnt[1:0]         per-master request / registered one-hot grant
//   sen_in, sclk_in, mosi_in    per-master SPI drive (sen_in active-low)
//   miso_out[1:0]               per-master MISO return
//   spi_sen/sclk/mosi, spi_miso shared bus
//   owner, busy                 current or most recent owner; FSM not idle
//   timeout_err, collision_err  single-cycle error pulses
//   trans_cnt0/1, timeout_cnt   statistics
//
// Build option: define E310_SPI_ARB_STATS_EN to build the statistics
// counters. When it is undefined they are tied to zero.
module e310_spi_arbiter #(
    parameter int GUARD_CYCLES  = 4,
    parameter int GRANT_TIMEOUT = 1024
) (
    input  logic        bus_clk,
    input  logic        bus_rst,
    input  logic [1:0]  req,
    output logic [1:0]  gnt,
    input  logic [1:0]  sen_in,
    input  logic [1:0]  sclk_in,
    input  logic [1:0]  mosi_in,
    output logic [1:0]  miso_out,
    output logic        spi_sen,
    output logic        spi_sclk,
    output logic        spi_mosi,
    input  logic        spi_miso,
    output logic        owner,
    output logic        busy,
    output logic        timeout_err,
    output logic        collision_err,
    output logic [15:0] trans_cnt0,
    output logic [15:0] trans_cnt1,
    output logic [7:0]  timeout_cnt
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_GRANT  = 2'd1;
    localparam logic [1:0] ST_ACTIVE = 2'd2;
    localparam logic [1:0] ST_GUARD  = 2'd3;

    localparam logic [7:0]  GUARD_LOAD = 8'(GUARD_CYCLES - 1);
    localparam logic [15:0] TMO_LAST   = 16'(GRANT_TIMEOUT - 1);

    logic [1:0]  state_reg, state_next;
    logic [1:0]  gnt_reg, gnt_next;
    logic        owner_reg, owner_next;
    logic        last_reg, last_next;
    logic [7:0]  guard_reg, guard_next;
    logic [15:0] tmo_reg, tmo_next;
    logic        tmo_err_reg, tmo_err_next;
    logic        coll_err_reg;
    logic [1:0]  sen_prev_reg;
    logic [1:0]  coll_hit;
    logic        sel;
    logic        owner_sen;
    logic        owner_req;

    assign owner_sen = sen_in[owner_reg];
    assign owner_req = req[owner_reg];

    // Round-robin: prefer the master that did not own the last transaction.
    assign sel = req[~last_reg] ? ~last_reg : last_reg;

    always_comb begin
        state_next   = state_reg;
        gnt_next     = gnt_reg;
        owner_next   = owner_reg;
        last_next    = last_reg;
        guard_next   = guard_reg;
        tmo_next     = tmo_reg;
        tmo_err_next = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (|req) begin
                    state_next = ST_GRANT;
                    owner_next = sel;
                    gnt_next   = sel ? 2'b10 : 2'b01;
                    tmo_next   = '0;
                end
            end
            ST_GRANT: begin
                // SEN already low counts as the start of the transfer.
                if (!owner_sen) begin
                    state_next = ST_ACTIVE;
                end else if (!owner_req) begin
                    // Withdrawn request: last owner is kept so fairness is unchanged.
                    state_next = ST_IDLE;
                    gnt_next   = '0;
                end else if (tmo_reg == TMO_LAST) begin
                    state_next   = ST_IDLE;
                    gnt_next     = '0;
                    tmo_err_next = 1'b1;
                    last_next    = owner_reg;
                end else begin
                    tmo_next = tmo_reg + 16'd1;
                end
            end
            ST_ACTIVE: begin
                // req is deliberately ignored here; only SEN ends the transfer.
                if (owner_sen) begin
                    state_next = ST_GUARD;
                    gnt_next   = '0;
                    guard_next = GUARD_LOAD;
                    last_next  = owner_reg;
                end
            end
            default: begin
                if (guard_reg == 8'd0) begin
                    state_next = ST_IDLE;
                end else begin
                    guard_next = guard_reg - 8'd1;
                end
            end
        endcase
    end

    // Falling SEN from the master that does not own the bus while it is busy.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_master
            assign coll_hit[gi] = (state_reg != ST_IDLE) && (owner_reg != 1'(gi))
                                  && sen_prev_reg[gi] && !sen_in[gi];
            assign miso_out[gi] = (state_reg == ST_ACTIVE) && (owner_reg == 1'(gi))
                                  && spi_miso;
        end
    endgenerate

    always_ff @(posedge bus_clk) begin
        if (bus_rst) begin
            state_reg    <= ST_IDLE;
            gnt_reg      <= '0;
            owner_reg    <= 1'b0;
            last_reg     <= 1'b1;
            guard_reg    <= '0;
            tmo_reg      <= '0;
            tmo_err_reg  <= 1'b0;
            coll_err_reg <= 1'b0;
            // Track live SEN through reset so a level held low is not seen as an edge.
            sen_prev_reg <= sen_in;
        end else begin
            state_reg    <= state_next;
            gnt_reg      <= gnt_next;
            owner_reg    <= owner_next;
            last_reg     <= last_next;
            guard_reg    <= guard_next;
            tmo_reg      <= tmo_next;
            tmo_err_reg  <= tmo_err_next;
            coll_err_reg <= |coll_hit;
            sen_prev_reg <= sen_in;
        end
    end

    // Shared bus follows the owner combinationally while granted or active.
    always_comb begin
        spi_sen  = 1'b1;
        spi_sclk = 1'b0;
        spi_mosi = 1'b0;
        if (state_reg == ST_GRANT || state_reg == ST_ACTIVE) begin
            spi_sen  = sen_in[owner_reg];
            spi_sclk = sclk_in[owner_reg];
            spi_mosi = mosi_in[owner_reg];
        end
    end

    assign gnt           = gnt_reg;
    assign owner         = owner_reg;
    assign busy          = (state_reg != ST_IDLE);
    assign timeout_err   = tmo_err_reg;
    assign collision_err = coll_err_reg;

`ifdef E310_SPI_ARB_STATS_EN
    logic [15:0] tc0_reg, tc1_reg;
    logic [7:0]  tmo_cnt_reg;
    logic        txn_done;

    assign txn_done = (state_reg == ST_ACTIVE) && owner_sen;

    always_ff @(posedge bus_clk) begin
        if (bus_rst) begin
            tc0_reg     <= '0;
            tc1_reg     <= '0;
            tmo_cnt_reg <= '0;
        end else begin
            if (txn_done && !owner_reg) tc0_reg <= tc0_reg + 16'd1;
            if (txn_done &&  owner_reg) tc1_reg <= tc1_reg + 16'd1;
            if (tmo_err_next && tmo_cnt_reg != 8'hFF) tmo_cnt_reg <= tmo_cnt_reg + 8'd1;
        end
    end

    assign trans_cnt0  = tc0_reg;
    assign trans_cnt1  = tc1_reg;
    assign timeout_cnt = tmo_cnt_reg;
`else
    assign trans_cnt0  = '0;
    assign trans_cnt1  = '0;
    assign timeout_cnt = '0;
`endif

endmodule

// File: tb/tb_e310_spi_arbiter.sv
// Testbench for e310_spi_arbiter: directed scenarios (single grant,
// contention, already-low SEN, timeout, collision, reset mid-transfer).
// A transaction-level model tracks who holds the bus, how long it has
// waited, and how many quiet cycles remain. The model is checked against
// every DUT output on each falling clock edge.
module tb_e310_spi_arbiter;

    localparam int GC = 4;
    localparam int GT = 8;
`ifdef E310_SPI_ARB_STATS_EN
    localparam int STATS = 1;
`else
    localparam int STATS = 0;
`endif

    logic        bus_clk = 1'b0;
    logic        bus_rst = 1'b1;
    logic [1:0]  req = 2'b00;
    logic [1:0]  gnt;
    logic [1:0]  sen_in = 2'b11;
    logic [1:0]  sclk_in = 2'b00;
    logic [1:0]  mosi_in = 2'b00;
    logic [1:0]  miso_out;
    logic        spi_sen, spi_sclk, spi_mosi;
    logic        spi_miso = 1'b0;
    logic        owner, busy, timeout_err, collision_err;
    logic [15:0] trans_cnt0, trans_cnt1;
    logic [7:0]  timeout_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 bus_clk = ~bus_clk;

    e310_spi_arbiter #(.GUARD_CYCLES(GC), .GRANT_TIMEOUT(GT)) dut (
        .bus_clk(bus_clk), .bus_rst(bus_rst), .req(req), .gnt(gnt),
        .sen_in(sen_in), .sclk_in(sclk_in), .mosi_in(mosi_in), .miso_out(miso_out),
        .spi_sen(spi_sen), .spi_sclk(spi_sclk), .spi_mosi(spi_mosi), .spi_miso(spi_miso),
        .owner(owner), .busy(busy), .timeout_err(timeout_err), .collision_err(collision_err),
        .trans_cnt0(trans_cnt0), .trans_cnt1(trans_cnt1), .timeout_cnt(timeout_cnt)
    );

    // Transaction-level model state. m_holder is -1 when nobody holds a grant.
    bit         m_valid = 0;
    int         m_holder, m_wait, m_quiet, m_owner, m_last;
    bit         m_xfer, m_tmo_err, m_coll_err;
    int         m_tc0, m_tc1, m_tmoc;
    logic [1:0] m_prev;
    int         tmo_pulses = 0;
    int         coll_pulses = 0;
    logic [7:0] pat = 8'd0;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        int eg;
        eg = (m_holder < 0) ? 0 : (1 << m_holder);
        chk("gnt", int'(gnt), eg);
        chk("busy", int'(busy), int'(m_holder >= 0 || m_quiet > 0));
        chk("owner", int'(owner), m_owner);
        chk("spi_sen", int'(spi_sen), (m_holder < 0) ? 1 : int'(sen_in[m_holder]));
        chk("spi_sclk", int'(spi_sclk), (m_holder < 0) ? 0 : int'(sclk_in[m_holder]));
        chk("spi_mosi", int'(spi_mosi), (m_holder < 0) ? 0 : int'(mosi_in[m_holder]));
        chk("miso_out", int'(miso_out), (m_xfer && spi_miso) ? (1 << m_holder) : 0);
        chk("timeout_err", int'(timeout_err), int'(m_tmo_err));
        chk("collision_err", int'(collision_err), int'(m_coll_err));
        chk("trans_cnt0", int'(trans_cnt0), STATS * m_tc0);
        chk("trans_cnt1", int'(trans_cnt1), STATS * m_tc1);
        chk("timeout_cnt", int'(timeout_cnt), STATS * m_tmoc);
    endtask

    // Advance the model over one clock edge using the inputs the DUT will sample.
    task automatic model_step();
        bit busy_now;
        if (bus_rst) begin
            m_valid = 1; m_holder = -1; m_xfer = 0; m_wait = 0; m_quiet = 0;
            m_owner = 0; m_last = 1; m_tmo_err = 0; m_coll_err = 0;
            m_tc0 = 0; m_tc1 = 0; m_tmoc = 0; m_prev = sen_in;
            return;
        end
        busy_now = (m_holder >= 0) || (m_quiet > 0);
        m_coll_err = 0;
        for (int i = 0; i < 2; i++)
            if (busy_now && i != m_owner && m_prev[i] && !sen_in[i]) m_coll_err = 1;
        m_prev = sen_in;
        m_tmo_err = 0;
        if (m_quiet > 0) begin
            m_quiet--;
        end else if (m_holder < 0) begin
            if (req != 2'b00) begin
                m_holder = req[1 - m_last] ? 1 - m_last : m_last;
                m_owner = m_holder; m_wait = 0; m_xfer = 0;
            end
        end else if (!m_xfer) begin
            if (!sen_in[m_holder]) m_xfer = 1;
            else if (!req[m_holder]) m_holder = -1;
            else if (m_wait + 1 == GT) begin
                m_tmo_err = 1; m_last = m_holder; m_holder = -1;
                if (m_tmoc < 255) m_tmoc++;
            end else m_wait++;
        end else if (sen_in[m_holder]) begin
            if (m_holder == 0) m_tc0 = (m_tc0 + 1) % 65536;
            else m_tc1 = (m_tc1 + 1) % 65536;
            $display("txn: master %0d released the bus at t=%0t", m_holder, $time);
            m_last = m_holder; m_holder = -1; m_xfer = 0; m_quiet = GC;
        end
    endtask

    // One clock: compare + model on the falling edge, then drive just after rising.
    task automatic tick();
        @(negedge bus_clk);
        if (m_valid) compare_all();
        if (timeout_err) tmo_pulses++;
        if (collision_err) coll_pulses++;
        model_step();
        @(posedge bus_clk);
        #1;
        pat = pat + 8'd1;
        sclk_in = pat[1:0];
        mosi_in = pat[2:1];
        spi_miso = pat[3];
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 40) begin tick(); n++; end
        chk("idle_reached", int'(busy), 0);
    endtask

    task automatic do_reset();
        bus_rst = 1'b1;
        repeat (3) tick();
        bus_rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, idx, base;

        // Single grant, 20-cycle transfer, guard length.
        do_reset();
        chk("rst_gnt", int'(gnt), 0);
        chk("rst_spi_sen", int'(spi_sen), 1);
        chk("rst_owner", int'(owner), 0);
        req = 2'b01;
        tick();
        chk("single_gnt", int'(gnt), 1);
        sen_in = 2'b10;
        repeat (20) tick();
        chk("single_spi_sen_low", int'(spi_sen), 0);
        sen_in = 2'b11; req = 2'b00;
        tick();
        n = 0;
        while (busy && n < 20) begin n++; tick(); end
        chk("guard_len", n, GC);
        chk("single_trans_cnt0", int'(trans_cnt0), STATS * 1);

        // Contention: both requesting, alternating grants, fixed gap.
        do_reset();
        req = 2'b11;
        for (int k = 0; k < 4; k++) begin
            n = 0;
            while (gnt == 2'b00 && n < 50) begin tick(); n++; end
            chk("grant_seen", int'(gnt != 2'b00), 1);
            idx = int'(gnt[1]);
            chk("grant_order", idx, k % 2);
            sen_in[idx] = 1'b0;
            repeat (16) tick();
            sen_in[idx] = 1'b1;
            n = 0;
            do begin tick(); n++; end while (gnt == 2'b00 && n < 50);
            chk("grant_gap", n, GC + 2);
        end
        req = 2'b00;
        tick();
        wait_idle();
        chk("contention_cnt1", int'(trans_cnt1), STATS * 2);

        // Master 1 already has SEN low when granted: no collision, active at once.
        base = coll_pulses;
        sen_in = 2'b01;
        tick();
        req = 2'b10;
        tick();
        chk("prelow_gnt", int'(gnt), 2);
        tick();
        req = 2'b00;
        tick();
        chk("prelow_still_busy", int'(busy), 1);
        chk("prelow_no_collision", coll_pulses - base, 0);
        sen_in = 2'b11;
        tick();
        wait_idle();

        // Timeout on master 1 with master 0 pending.
        base = tmo_pulses;
        req = 2'b10;
        tick();
        req = 2'b11;
        n = 0;
        while (gnt[1] && n < 30) begin n++; tick(); end
        chk("timeout_gnt_len", n, GT);
        tick();
        chk("after_timeout_gnt", int'(gnt), 1);
        chk("timeout_pulses", tmo_pulses - base, 1);
        chk("timeout_cnt", int'(timeout_cnt), STATS * 1);

        // Collision: master 1 drops SEN while master 0 is active.
        req = 2'b01; sen_in = 2'b10;
        repeat (3) tick();
        base = coll_pulses;
        sen_in = 2'b00;
        tick();
        chk("coll_spi_sen", int'(spi_sen), 0);
        chk("coll_miso1", int'(miso_out[1]), 0);
        repeat (3) tick();
        sen_in = 2'b10;
        tick();
        chk("coll_pulses", coll_pulses - base, 1);
        sen_in = 2'b11; req = 2'b00;
        tick();
        wait_idle();

        // Reset ten cycles into a transfer.
        req = 2'b01;
        tick();
        sen_in = 2'b10;
        repeat (10) tick();
        bus_rst = 1'b1;
        tick();
        chk("midrst_spi_sen", int'(spi_sen), 1);
        chk("midrst_gnt", int'(gnt), 0);
        chk("midrst_cnt0", int'(trans_cnt0), 0);
        bus_rst = 1'b0; sen_in = 2'b11; req = 2'b11;
        tick();
        chk("midrst_first_gnt", int'(gnt), 1);
        req = 2'b00;
        tick();
        wait_idle();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
